// File: rtl/switch_input_pio.sv
// Avalon-MM switch input PIO: per-bit synchronize + debounce, edge capture with
// write-1-to-clear, masked level interrupt.

module switch_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module switch_input_pio #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] stable, stable_d, irqmask, edgecapture;
    logic [WIDTH-1:0] rise, fall, edge_set, clr;
    logic             wr;
    logic             unused_wd;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            switch_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk    (clk),
                .reset_n(reset_n),
                .din    (in_port[i]),
                .stable (stable[i])
            );
        end
    endgenerate

    assign wr        = chipselect & ~write_n;
    assign rise      = stable & ~stable_d;
    assign fall      = ~stable & stable_d;
    assign clr       = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign unused_wd = ^writedata;

    always_comb begin
        edge_set = rise | fall;
        if (EDGE_MODE == 0)      edge_set = rise;
        else if (EDGE_MODE == 1) edge_set = fall;
    end

    // New edges win over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d    <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
        end else begin
            stable_d    <= stable;
            edgecapture <= (edgecapture & ~clr) | edge_set;
            if (wr && address == 2'd2)
                irqmask <= writedata[WIDTH-1:0];
            case (address)
                2'd0:    readdata <= 32'(stable);
                2'd2:    readdata <= 32'(irqmask);
                2'd3:    readdata <= 32'(edgecapture);
                default: readdata <= '0;
            endcase
        end
    end

    assign irq = |(edgecapture & irqmask);
endmodule

// File: tb/tb_switch_input_pio.sv
// Bench for switch_input_pio: three instances (EDGE_MODE 2/0/1, DEBOUNCE_CYCLES=4)
// share one bus; reads are checked against a queue of expected values.

module tb_switch_input_pio;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata;
    logic [9:0]  in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [95:0] exp_q[$];
    logic        chk = 1'b0;

    always #5 clk = ~clk;

    switch_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) u_both (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));
    switch_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));
    switch_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));

    // Scoreboard: pops one expected triple per read, 1 cycle after issue.
    always @(posedge clk) begin
        if (chk) begin
            logic [95:0] e;
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL sb_underflow addr=%0d", address);
            end else begin
                e = exp_q.pop_front();
                n_cmp += 3;
                if (rd0 !== e[95:64]) begin n_fail++; $display("FAIL rd_both addr=%0d got=%h exp=%h", address, rd0, e[95:64]); end
                if (rd1 !== e[63:32]) begin n_fail++; $display("FAIL rd_rise addr=%0d got=%h exp=%h", address, rd1, e[63:32]); end
                if (rd2 !== e[31:0])  begin n_fail++; $display("FAIL rd_fall addr=%0d got=%h exp=%h", address, rd2, e[31:0]); end
            end
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e0, e1, e2);
        address = a;
        exp_q.push_back({e0, e1, e2});
        chk = 1'b1;
        @(negedge clk);
        chk = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic chk_irq(input string name, input logic e0, e1, e2);
        n_cmp += 3;
        if (irq0 !== e0) begin n_fail++; $display("FAIL %s irq_both got=%b exp=%b", name, irq0, e0); end
        if (irq1 !== e1) begin n_fail++; $display("FAIL %s irq_rise got=%b exp=%b", name, irq1, e1); end
        if (irq2 !== e2) begin n_fail++; $display("FAIL %s irq_fall got=%b exp=%b", name, irq2, e2); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        tick(2);
        n_cmp += 3;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset rd_both got=%h exp=0", rd0); end
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset rd_rise got=%h exp=0", rd1); end
        if (rd2 !== 32'h0) begin n_fail++; $display("FAIL reset rd_fall got=%h exp=0", rd2); end
        chk_irq("reset", 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick(3);
        rd(2'd0, 0, 0, 0);
        rd(2'd3, 0, 0, 0);
    endtask

    // 0->1 on bit 0: visible on a read latched at clock 7, not at clock 6.
    task automatic test_debounce();
        in_port[0] = 1'b1;
        tick(5);
        rd(2'd0, 32'h0, 32'h0, 32'h0);
        rd(2'd0, 32'h1, 32'h1, 32'h1);
        rd(2'd3, 32'h1, 32'h1, 32'h0);
    endtask

    task automatic test_glitch();
        in_port[3] = 1'b1;
        tick(3);
        in_port[3] = 1'b0;
        tick(8);
        rd(2'd0, 32'h1, 32'h1, 32'h1);
        rd(2'd3, 32'h1, 32'h1, 32'h0);
        chk_irq("glitch", 1'b0, 1'b0, 1'b0);
        // A 4-clock pulse is just long enough to be accepted both ways.
        in_port[5] = 1'b1;
        tick(4);
        in_port[5] = 1'b0;
        tick(12);
        rd(2'd0, 32'h1, 32'h1, 32'h1);
        rd(2'd3, 32'h21, 32'h21, 32'h20);
    endtask

    task automatic test_irq();
        wr(2'd2, 32'h1);
        chk_irq("irq_set", 1'b1, 1'b1, 1'b0);
        wr(2'd3, 32'h1);
        chk_irq("irq_clr", 1'b0, 1'b0, 1'b0);
        rd(2'd3, 32'h20, 32'h20, 32'h20);
        rd(2'd2, 32'h1, 32'h1, 32'h1);
    endtask

    task automatic test_set_beats_clear();
        in_port[0] = 1'b0;
        tick(6);
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h21, 32'h20, 32'h21);
        chk_irq("set_vs_clr", 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_map();
        in_port = 10'h3FF;
        tick(10);
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd0, 32'h3FF, 32'h3FF, 32'h3FF);
        rd(2'd1, 32'h0, 32'h0, 32'h0);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'h3FF, 32'h3FF, 32'h3FF);
        rd(2'd3, 32'h3FF, 32'h3FF, 32'h21);
        chk_irq("map_irq", 1'b1, 1'b1, 1'b1);
        wr(2'd3, 32'h3FF);
        chk_irq("map_clr", 1'b0, 1'b0, 1'b0);
        rd(2'd3, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid_debounce();
        in_port = 10'h0;
        tick(3);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        rd(2'd3, 0, 0, 0);
        rd(2'd0, 0, 0, 0);
        rd(2'd2, 0, 0, 0);
        chk_irq("mid_rst", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_held_through_reset();
        in_port = 10'h001;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        rd(2'd0, 32'h0, 32'h0, 32'h0);
        rd(2'd0, 32'h1, 32'h1, 32'h1);
        rd(2'd3, 32'h1, 32'h1, 32'h0);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_irq();
        test_set_beats_clear();
        test_map();
        test_reset_mid_debounce();
        test_held_through_reset();
        tick(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
